// File: rtl/eqx_pkg.sv
// Shared types and constants for the 2-bit equality-compare sweep checker.
// Bit positions follow the compare block's y1 result vector.
package eqx_pkg;

  localparam int Y1_W  = 9;
  localparam int N_VEC = 4;

  localparam int EQ00 = 8;
  localparam int EQ01 = 7;
  localparam int EQ0X = 6;
  localparam int EQ10 = 5;
  localparam int EQ11 = 4;
  localparam int EQ1X = 3;
  localparam int EQX0 = 2;
  localparam int EQX1 = 1;
  localparam int EQXX = 0;

  // Compares with an x operand; only meaningful under a 4-state simulator.
  localparam logic [Y1_W-1:0] XCMP_MASK = Y1_W'((1 << EQ0X) | (1 << EQ1X) | (1 << EQX0) |
                                               (1 << EQX1) | (1 << EQXX));

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StFinish
  } state_t;

  function automatic logic [Y1_W-1:0] golden_y1(input logic [1:0] idx);
    logic [Y1_W-1:0] v;
    v = '0;
    case (idx)
      2'd0:    v[EQ00] = 1'b1;
      2'd1:    v[EQ01] = 1'b1;
      2'd2:    v[EQ10] = 1'b1;
      default: v[EQ11] = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/eqx_golden_cmp.sv
// Combinational check of one y1 response against the golden one-hot for a stimulus index.
module eqx_golden_cmp
  import eqx_pkg::*;
(
  input  logic [1:0]      idx,
  input  logic [Y1_W-1:0] y1,
  input  logic [Y1_W-1:0] mask,
  output logic            mismatch
);

  logic [Y1_W-1:0] w_golden;

  assign w_golden = golden_y1(idx);
  assign mismatch = |((y1 ^ w_golden) & mask);

endmodule

// File: rtl/eqx_sweep_checker.sv
// Drives the compare block through a = 0..3, samples each y1 response after a settle
// window, checks masked bits against the golden table and logs every raw response.
module eqx_sweep_checker
  import eqx_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 1,
  parameter logic [8:0]      CHECK_MASK    = 9'h1B0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  dut_a,
  input  logic [8:0]  dut_y1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_cnt,
  output logic [1:0]  first_fail,
  output logic        first_fail_vld,
  output logic [35:0] log
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LastIdx    = 2'(N_VEC - 1);
  localparam logic [2:0] ErrMax     = 3'(N_VEC);

  state_t                  r_state;
  logic [1:0]              r_idx;
  logic [3:0]              r_cnt;
  logic [1:0]              r_dut_a;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic [2:0]              r_err_cnt;
  logic [1:0]              r_first_fail;
  logic                    r_first_fail_vld;
  logic [Y1_W*N_VEC-1:0]   r_log;
  logic                    w_mismatch;

  eqx_golden_cmp u_cmp (
    .idx      (r_idx),
    .y1       (dut_y1),
    .mask     (CHECK_MASK),
    .mismatch (w_mismatch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= StIdle;
      r_idx            <= '0;
      r_cnt            <= '0;
      r_dut_a          <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
      r_log            <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_err_cnt        <= '0;
            r_first_fail_vld <= 1'b0;
            r_log            <= '0;
            r_idx            <= '0;
            r_busy           <= 1'b1;
            r_state          <= StDrive;
          end
        end
        StDrive: begin
          r_dut_a <= r_idx;
          r_cnt   <= SettleInit;
          r_state <= StSettle;
        end
        StSettle: begin
          if (r_cnt == 4'd0) begin
            r_state <= StSample;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StSample: begin
          r_log[Y1_W*r_idx +: Y1_W] <= dut_y1;
          if (w_mismatch) begin
            if (r_err_cnt < ErrMax) begin
              r_err_cnt <= r_err_cnt + 3'd1;
            end
            if (!r_first_fail_vld) begin
              r_first_fail     <= r_idx;
              r_first_fail_vld <= 1'b1;
            end
          end
          if (r_idx == LastIdx) begin
            // done is registered, so it is high for exactly the FINISH cycle.
            r_done  <= 1'b1;
            r_state <= StFinish;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= StDrive;
          end
        end
        StFinish: begin
          r_pass  <= (r_err_cnt == 3'd0);
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dut_a          = r_dut_a;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_fail     = r_first_fail;
  assign first_fail_vld = r_first_fail_vld;
  assign log            = r_log;

endmodule
